gpio_input: RTL

// - Input-side counterpart of the GPIO output register. Samples WIDTH external pins,

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_in_bit.sv | 69 ++++++
 rtl/gpio_input.sv | 100 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : gpio_pkg                                                        |
// | Purpose  : Shared register map and defaults for the GPIO input block.      |
// | Contents : GPIO_IN_* register addresses, default pin count, address type.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package gpio_pkg;

  typedef logic [2:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_IN_DATA    = 3'd0;
  localparam gpio_addr_t GPIO_IN_RISE_EN = 3'd1;
  localparam gpio_addr_t GPIO_IN_FALL_EN = 3'd2;
  localparam gpio_addr_t GPIO_IN_STATUS  = 3'd3;

  localparam int GPIO_IN_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/gpio_in_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_in_bit                                                     |
// | Purpose  : One input pin: synchronizer chain, debounce counter and         |
// |            single-cycle rise/fall pulses on accepted level changes.        |
// | Ports    : clk, reset (async, active-high)                                 |
// |            pin_i  - raw asynchronous pin                                   |
// |            deb_o  - debounced level                                        |
// |            rise_o - high in the cycle whose edge sets deb 0->1             |
// |            fall_o - high in the cycle whose edge sets deb 1->0             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic deb_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_LEN) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   deb_q;
  logic [CNT_W-1:0]       cnt_q;

  logic w_sync;
  logic w_differ;
  logic w_accept;

  assign w_sync   = sync_q[SYNC_STAGES-1];
  assign w_differ = (w_sync != deb_q);
  // The counter has already seen DEBOUNCE_LEN-1 differing cycles; this one
  // makes DEBOUNCE_LEN, so the new level is taken on this edge.
  assign w_accept = w_differ && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      if (!w_differ) begin
        cnt_q <= '0;
      end else if (w_accept) begin
        deb_q <= w_sync;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign deb_o  = deb_q;
  // Pulses are combinational so the status register can latch them on the
  // same edge that updates deb.
  assign rise_o = w_accept &  w_sync;
  assign fall_o = w_accept & ~w_sync;

endmodule
`default_nettype wire

// File: rtl/gpio_input.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gpio_input                                                      |
// | Purpose  : WIDTH debounced input pins with sticky rise/fall status bits,   |
// |            CPU register interface and level interrupt.                     |
// | Ports    : clk, reset (async, active-high)                                 |
// |            we, re, addr[2:0], data_in[WIDTH] - register bus                |
// |            data_out[WIDTH] - registered read data (0 when re=0)            |
// |            gpio_in[WIDTH]  - asynchronous pins                             |
// |            irq             - registered OR of STATUS                       |
// | Map      : 0 DATA (RO), 1 RISE_EN, 2 FALL_EN, 3 STATUS (W1C), 4-7 zero     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module gpio_input
  import gpio_pkg::*;
#(
  parameter int WIDTH        = GPIO_IN_WIDTH,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             irq
);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;
  logic [WIDTH-1:0] data_out_q;
  logic             irq_q;

  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_rd_data;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_in_bit #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_LEN (DEBOUNCE_LEN)
      ) u_bit (
        .clk    (clk),
        .reset  (reset),
        .pin_i  (gpio_in[i]),
        .deb_o  (w_deb[i]),
        .rise_o (w_rise[i]),
        .fall_o (w_fall[i])
      );
    end
  endgenerate

  // Clear is applied before set, so an event maturing on the clearing edge
  // survives.
  always_comb begin
    w_w1c    = (we && (addr == GPIO_IN_STATUS)) ? data_in : '0;
    status_d = (status_q & ~w_w1c) | (w_rise & rise_en_q) | (w_fall & fall_en_q);
  end

  always_comb begin
    w_rd_data = '0;
    case (addr)
      GPIO_IN_DATA:    w_rd_data = w_deb;
      GPIO_IN_RISE_EN: w_rd_data = rise_en_q;
      GPIO_IN_FALL_EN: w_rd_data = fall_en_q;
      GPIO_IN_STATUS:  w_rd_data = status_q;
      default:         w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      if (we && (addr == GPIO_IN_RISE_EN)) rise_en_q <= data_in;
      if (we && (addr == GPIO_IN_FALL_EN)) fall_en_q <= data_in;
      status_q   <= status_d;
      irq_q      <= |status_d;
      data_out_q <= re ? w_rd_data : '0;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire
